// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one uart_tx among NUM_REQ byte requesters,
// with a per-byte completion timeout and a sticky timeout error flag.
module uart_tx_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic [NUM_REQ-1:0]     req,
   input  logic [8*NUM_REQ-1:0]   req_data,
   output logic [NUM_REQ-1:0]     grant,
   output logic [NUM_REQ-1:0]     done,
   output logic                   uart_tx_start,
   output logic [7:0]             uart_tx_data,
   input  logic                   uart_tx_done,
   output logic                   busy,
   output logic                   timeout_err,
   input  logic                   err_clear
);

   localparam int PW = $clog2(NUM_REQ);
   localparam int CW = $clog2(TIMEOUT_CYCLES);
   localparam logic [CW-1:0]      CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0]      CNT_ONE  = CW'(1'b1);
   localparam logic [PW-1:0]      PTR_LAST = PW'(NUM_REQ - 1);
   localparam logic [PW-1:0]      PTR_ONE  = PW'(1'b1);
   localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_GRANT    = 2'd1,
      ST_WAIT     = 2'd2,
      ST_COMPLETE = 2'd3
   } state_t;

   // First high request found searching p, p+1, ... modulo NUM_REQ.
   function automatic logic [PW-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                             input logic [PW-1:0]      p);
      logic [2*NUM_REQ-1:0] dbl;
      logic [NUM_REQ-1:0]   rot;
      logic [PW:0]          sum;
      logic                 found;
      logic [PW-1:0]        w;
      dbl   = {r, r} >> p;
      rot   = dbl[NUM_REQ-1:0];
      found = 1'b0;
      w     = p;
      for (int i = 0; i < NUM_REQ; i++) begin
         sum = {1'b0, p} + (PW+1)'(i);
         sum = (sum >= (PW+1)'(NUM_REQ)) ? (sum - (PW+1)'(NUM_REQ)) : sum;
         if (!found && rot[i[PW-1:0]]) begin
            w     = sum[PW-1:0];
            found = 1'b1;
         end
      end
      return w;
   endfunction

   function automatic logic [PW-1:0] ptr_after(input logic [PW-1:0] w);
      return (w == PTR_LAST) ? {PW{1'b0}} : (w + PTR_ONE);
   endfunction

   state_t               state_r;
   logic [PW-1:0]        ptr_r;
   logic [PW-1:0]        win_r;
   logic [CW-1:0]        cnt_r;
   logic [NUM_REQ-1:0]   grant_r;
   logic [NUM_REQ-1:0]   done_r;
   logic                 start_r;
   logic [7:0]           data_r;
   logic                 busy_r;
   logic                 err_r;

   logic                 any_req_s;
   logic [PW-1:0]        pick_s;
   logic [7:0]           pick_data_s;
   logic                 err_set_s;

   // Winner selection and the abort condition, evaluated every cycle.
   always_comb begin
      any_req_s   = |req;
      pick_s      = rr_pick(req, ptr_r);
      pick_data_s = req_data[{pick_s, 3'b000} +: 8];
      err_set_s   = (state_r == ST_WAIT) && !uart_tx_done && (cnt_r == CNT_LAST);
   end

   // Transmit sequencer: arbitration, start pulse, completion/timeout, error flag.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_r <= ST_IDLE;
         ptr_r   <= {PW{1'b0}};
         win_r   <= {PW{1'b0}};
         cnt_r   <= {CW{1'b0}};
         grant_r <= {NUM_REQ{1'b0}};
         done_r  <= {NUM_REQ{1'b0}};
         start_r <= 1'b0;
         data_r  <= 8'h00;
         busy_r  <= 1'b0;
         err_r   <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (any_req_s) begin
                  win_r   <= pick_s;
                  grant_r <= ONE_HOT0 << pick_s;
                  start_r <= 1'b1;
                  data_r  <= pick_data_s;
                  busy_r  <= 1'b1;
                  state_r <= ST_GRANT;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_GRANT: begin
               grant_r <= {NUM_REQ{1'b0}};
               start_r <= 1'b0;
               cnt_r   <= {CW{1'b0}};
               state_r <= ST_WAIT;
            end
            ST_WAIT: begin
               // Completion is checked before the abort so a coincident done still succeeds.
               if (uart_tx_done) begin
                  done_r  <= ONE_HOT0 << win_r;
                  ptr_r   <= ptr_after(win_r);
                  state_r <= ST_COMPLETE;
               end else if (cnt_r == CNT_LAST) begin
                  ptr_r   <= ptr_after(win_r);
                  state_r <= ST_COMPLETE;
               end else begin
                  cnt_r   <= cnt_r + CNT_ONE;
               end
            end
            ST_COMPLETE: begin
               done_r  <= {NUM_REQ{1'b0}};
               busy_r  <= 1'b0;
               state_r <= ST_IDLE;
            end
            default: begin
               grant_r <= {NUM_REQ{1'b0}};
               done_r  <= {NUM_REQ{1'b0}};
               start_r <= 1'b0;
               busy_r  <= 1'b0;
               state_r <= ST_IDLE;
            end
         endcase

         if (err_set_s) begin
            err_r <= 1'b1;
         end else if (err_clear) begin
            err_r <= 1'b0;
         end else begin
            err_r <= err_r;
         end
      end
   end

   assign grant         = grant_r;
   assign done          = done_r;
   assign uart_tx_start = start_r;
   assign uart_tx_data  = data_r;
   assign busy          = busy_r;
   assign timeout_err   = err_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: directed scenarios plus randomized
// traffic, checked against a cycle-count transaction model.
module tb_uart_tx_arbiter;

   localparam int N = 4;
   localparam int T = 16;

   logic           clk = 1'b0;
   logic           rstn;
   logic [N-1:0]   req;
   logic [8*N-1:0] req_data;
   logic [N-1:0]   grant;
   logic [N-1:0]   done;
   logic           uart_tx_start;
   logic [7:0]     uart_tx_data;
   logic           uart_tx_done;
   logic           busy;
   logic           timeout_err;
   logic           err_clear;

   uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(T)) dut (
      .clk(clk), .rstn(rstn), .req(req), .req_data(req_data),
      .grant(grant), .done(done), .uart_tx_start(uart_tx_start),
      .uart_tx_data(uart_tx_data), .uart_tx_done(uart_tx_done),
      .busy(busy), .timeout_err(timeout_err), .err_clear(err_clear)
   );

   always #5 clk = ~clk;

   typedef struct { bit is_done; int idx; } ev_t;
   typedef struct { bit busy; bit err; bit start; logic [7:0] data; } st_t;

   ev_t ev_q[$];
   st_t st_q[$];
   int  tests = 0;
   int  fails = 0;

   // stimulus state
   logic       rstn_v;
   logic [N-1:0] req_v;
   logic [7:0] data_v[N];
   logic       err_clear_v;
   bit         auto_mode;
   logic [N-1:0] sticky_v;
   int         fixed_delay;
   int         e;
   int         pend_done;
   int         last_grant;

   // reference model state
   bit         m_busy, m_resolved, m_err;
   int         m_ptr, m_win, m_g, m_o;
   logic [7:0] m_data;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
      end
   endtask

   // Apply inputs for the next edge, predict its effect, then advance one cycle.
   task automatic drive_edge();
      bit  txd, start, err_set;
      int  w;
      ev_t ev;
      st_t st;
      if (last_grant >= 0 && !sticky_v[last_grant] &&
          (!auto_mode || $urandom_range(0, 3) != 0))
         req_v[last_grant] = 1'b0;
      last_grant = -1;
      if (auto_mode) begin
         for (int i = 0; i < N; i++) begin
            if (!req_v[i] && $urandom_range(0, 3) == 0) begin
               req_v[i]  = 1'b1;
               data_v[i] = 8'($urandom);
            end
         end
      end
      txd = (e == pend_done);
      rstn = rstn_v;
      req  = req_v;
      for (int i = 0; i < N; i++) req_data[8*i +: 8] = data_v[i];
      uart_tx_done = txd;
      err_clear    = err_clear_v;

      start   = 1'b0;
      err_set = 1'b0;
      if (!rstn_v) begin
         m_busy = 1'b0; m_ptr = 0; m_err = 1'b0; m_data = 8'h00; pend_done = -1;
      end else begin
         if (m_busy) begin
            if (!m_resolved && e >= m_g + 2) begin
               if (txd) begin
                  ev.is_done = 1'b1; ev.idx = m_win; ev_q.push_back(ev);
                  m_resolved = 1'b1; m_o = e; m_ptr = (m_win + 1) % N;
               end else if (e == m_g + 1 + T) begin
                  err_set = 1'b1;
                  m_resolved = 1'b1; m_o = e; m_ptr = (m_win + 1) % N;
               end
            end else if (m_resolved && e == m_o + 1) begin
               m_busy = 1'b0;
            end
         end else if (req_v != '0) begin
            w = -1;
            for (int k = 0; k < N; k++)
               if (w < 0 && req_v[(m_ptr + k) % N]) w = (m_ptr + k) % N;
            m_win = w; m_g = e; m_busy = 1'b1; m_resolved = 1'b0;
            m_data = data_v[w]; start = 1'b1;
            ev.is_done = 1'b0; ev.idx = w; ev_q.push_back(ev);
            last_grant = w;
            pend_done = e + 1 + ((fixed_delay > 0) ? fixed_delay : $urandom_range(1, T + 3));
         end
         if (err_set) m_err = 1'b1;
         else if (err_clear_v) m_err = 1'b0;
      end
      st.busy = m_busy; st.err = m_err; st.start = start; st.data = m_data;
      st_q.push_back(st);
      @(posedge clk);
      #1;
      e++;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) drive_edge();
   endtask

   // Monitor: one status record per edge, one event per grant/done pulse.
   always @(negedge clk) begin
      st_t s;
      ev_t x;
      if (st_q.size() != 0) begin
         s = st_q.pop_front();
         chk("busy", 32'(busy), 32'(s.busy));
         chk("timeout_err", 32'(timeout_err), 32'(s.err));
         chk("uart_tx_start", 32'(uart_tx_start), 32'(s.start));
         chk("uart_tx_data", 32'(uart_tx_data), 32'(s.data));
      end
      if (grant != '0 || done != '0) begin
         if (ev_q.size() == 0) begin
            chk("unexpected_pulse", 32'({done, grant}), 32'h0);
         end else begin
            x = ev_q.pop_front();
            chk(x.is_done ? "done_onehot" : "grant_onehot", 32'({done, grant}),
                x.is_done ? (32'h1 << (x.idx + N)) : (32'h1 << x.idx));
         end
      end
   end

   initial begin
      rstn_v = 1'b0; req_v = '0; err_clear_v = 1'b0; auto_mode = 1'b0;
      sticky_v = '0; fixed_delay = 0; e = 0; pend_done = -1; last_grant = -1;
      m_busy = 1'b0; m_resolved = 1'b0; m_err = 1'b0; m_ptr = 0; m_win = 0;
      m_g = 0; m_o = 0; m_data = 8'h00;
      for (int i = 0; i < N; i++) data_v[i] = 8'h00;

      // reset held with random requests
      for (int i = 0; i < 3; i++) begin
         req_v = 4'($urandom);
         for (int j = 0; j < N; j++) data_v[j] = 8'($urandom);
         drive_edge();
      end
      rstn_v = 1'b1; req_v = '0;
      run(2);

      // single request, completion 10 cycles after start
      data_v[2] = 8'hA5; req_v = 4'b0100; fixed_delay = 9;
      run(16);

      // all four requesting from a fresh reset: order 0,1,2,3
      rstn_v = 1'b0; drive_edge(); rstn_v = 1'b1;
      for (int j = 0; j < N; j++) data_v[j] = 8'($urandom);
      req_v = 4'b1111; fixed_delay = 0;
      run(80);

      // requester 0 held permanently, requester 3 arrives during its WAIT
      sticky_v = 4'b0001; req_v = 4'b0001; fixed_delay = 6;
      run(3);
      req_v[3] = 1'b1; data_v[3] = 8'h3C;
      run(30);
      sticky_v = '0; req_v = '0;
      run(12);

      // done coincident with the last WAIT cycle still succeeds
      req_v = 4'b0001; data_v[0] = 8'h5A; fixed_delay = T;
      run(22);

      // timeout without completion, then err_clear
      req_v = 4'b0010; data_v[1] = 8'hC3; fixed_delay = T + 3;
      run(24);
      err_clear_v = 1'b1; drive_edge(); err_clear_v = 1'b0;
      run(2);

      // reset while requester 2 is in WAIT (ptr=2), then all request
      req_v = 4'b0100; data_v[2] = 8'h77;
      run(6);
      rstn_v = 1'b0; run(2); rstn_v = 1'b1;
      req_v = 4'b1111; fixed_delay = 0;
      run(20);

      // randomized traffic with occasional err_clear and reset
      auto_mode = 1'b1;
      for (int i = 0; i < 2500; i++) begin
         err_clear_v = ($urandom_range(0, 7) == 0);
         rstn_v      = ($urandom_range(0, 299) != 0);
         drive_edge();
      end
      auto_mode = 1'b0; rstn_v = 1'b1; err_clear_v = 1'b0; req_v = '0;
      run(25);

      @(negedge clk);
      #1;
      chk("events_drained", 32'(ev_q.size()), 32'h0);
      chk("status_drained", 32'(st_q.size()), 32'h0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, SHALL set the number of requester channels (2..8).
REQ-002 Parameter TIMEOUT_CYCLES, default 4096, SHALL set the maximum WAIT-state cycles before abort (>=2).
REQ-003 clk  input  1  SHALL be the clock; all state updates on posedge clk.
REQ-004 rstn  input  1  SHALL be the reset: synchronous, active-low.
REQ-005 req  input  NUM_REQ  SHALL carry per-requester transmit requests; held high until granted.
REQ-006 req_data  input  8*NUM_REQ  SHALL carry the byte for requester i in bits [8i+7:8i]; stable while req[i]=1.
REQ-007 grant  output  NUM_REQ  SHALL be a one-hot one-cycle pulse acknowledging acceptance of the winner's byte.
REQ-008 done  output  NUM_REQ  SHALL be a one-hot one-cycle pulse marking successful transmission for that requester.
REQ-009 uart_tx_start  output  1  SHALL be a one-cycle start pulse to the shared uart_tx.
REQ-010 uart_tx_data  output  8  SHALL be the byte presented to uart_tx; held through WAIT.
REQ-011 uart_tx_done  input  1  SHALL be the completion indication from uart_tx.
REQ-012 busy  output  1  SHALL be high whenever the FSM is not in IDLE.
REQ-013 timeout_err  output  1  SHALL be a sticky flag set on a transmit timeout.
REQ-014 err_clear  input  1  SHALL clear timeout_err when high.

Function
REQ-015 FSM states SHALL be IDLE, GRANT, WAIT and COMPLETE; every output SHALL be registered.
REQ-016 IDLE: if any req bit is high at an edge, that edge SHALL select winner w, set grant[w]=1 and uart_tx_start=1, load uart_tx_data=req_data[w], and enter GRANT; otherwise the FSM SHALL stay in IDLE.
REQ-017 Arbitration SHALL be round-robin: search order ptr, ptr+1, ... modulo NUM_REQ, with the first high req bit winning.
REQ-018 ptr SHALL reset to 0 and SHALL update to (w+1) mod NUM_REQ on leaving WAIT by either exit.
REQ-019 GRANT SHALL last exactly one cycle; the next edge SHALL clear grant and uart_tx_start, clear the timeout counter, and enter WAIT.
REQ-020 WAIT: the timeout counter SHALL increment each cycle.
REQ-021 WAIT: uart_tx_done=1 SHALL set done[w]=1 for one cycle and enter COMPLETE.
REQ-022 WAIT: when the counter reaches TIMEOUT_CYCLES-1 without uart_tx_done, the FSM SHALL set timeout_err=1, emit no done pulse, and enter COMPLETE.
REQ-023 uart_tx_done and timeout in the same cycle SHALL be treated as success (done wins).
REQ-024 COMPLETE SHALL clear done and return to IDLE after one cycle, giving a minimum 4-cycle request-to-request spacing.
REQ-025 uart_tx_done while not in WAIT SHALL be ignored.
REQ-026 A requester's req SHALL NOT be cleared by the block; a req still high in IDLE SHALL be re-arbitrated normally.
REQ-027 err_clear=1 SHALL clear timeout_err; a timeout set in the same cycle SHALL win.
REQ-028 uart_tx_data SHALL retain its last value in IDLE.
REQ-029 The counter width SHALL be $clog2(TIMEOUT_CYCLES) and SHALL NOT wrap before the abort.

Reset
REQ-030 rstn=0 at an edge SHALL force state=IDLE, ptr=0, counter=0, and set grant, done, uart_tx_start, uart_tx_data, timeout_err and busy to 0, regardless of the current state.
REQ-031 Reset mid-WAIT SHALL abandon the byte with no done pulse, and the first post-reset arbitration SHALL start from requester 0.

Verification
REQ-032 Hold rstn=0 for 3 cycles with random req -> all outputs 0 and busy=0.
REQ-033 req=0100, req_data[23:16]=0xA5, uart_tx_done pulsed 10 cycles after start -> grant=0100 and uart_tx_start for one cycle, uart_tx_data=0xA5, done=0100 one cycle after the uart_tx_done edge, then busy=0.
REQ-034 req=1111 held after reset, each requester dropping req after its grant -> grant order 0001, 0010, 0100, 1000 with exactly one start per grant.
REQ-035 req[0] held permanently plus req[3] raised during requester 0's WAIT -> next grant goes to 1000, then 0001 (no starvation).
REQ-036 TIMEOUT_CYCLES=16, no uart_tx_done -> timeout_err=1 after 16 WAIT cycles, no done pulse, return to IDLE; err_clear pulse -> timeout_err=0.
REQ-037 rstn=0 in WAIT with ptr=2 -> no done pulse; next req=1111 -> grant=0001.
